// File: rtl/passcode_entry.sv
// Keypad front end of the door lock: edge-detects start/digit/end buttons, collects a passcode, opens the door or locks out after repeated failures.
// Latency: button edge registered one clock, FSM reacts the next; door_open/fail/locked rise two clocks after ps_end is first sampled high.
// No backpressure: button events arriving while the FSM is not listening (CHECK/OPEN/FAIL/LOCK) are dropped. Optional MASK_DISPLAY_EN shows entered digits as dashes (4'hA).
module passcode_entry #(
  parameter int                      NUM_DIGITS  = 6,
  parameter logic [4*NUM_DIGITS-1:0] PASSCODE    = 24'h123456,
  parameter int                      MAX_FAIL    = 3,
  parameter int                      OPEN_CYCLES = 500,
  parameter int                      LOCK_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ps_start,
  input  logic [3:0]                ps_num,
  input  logic                      ps_num_valid,
  input  logic                      ps_end,
  output logic                      door_open,
  output logic                      fail,
  output logic                      locked,
  output logic [2:0]                entry_cnt,
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic [2:0]                state_out
);

  localparam int DW   = 4 * NUM_DIGITS;
  localparam int FW   = (MAX_FAIL > 1) ? $clog2(MAX_FAIL) : 1;
  localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [DW-1:0] BLANK = {DW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_CHECK = 3'd2,
    S_OPEN  = 3'd3,
    S_FAIL  = 3'd4,
    S_LOCK  = 3'd5
  } state_t;

  state_t          r_state;
  logic            r_start_d, r_num_vld_d, r_end_d;
  logic            r_ev_start, r_ev_num, r_ev_end;
  logic [3:0]      r_num_q;
  logic [DW-1:0]   r_digits;
  logic [2:0]      r_cnt;
  logic [FW-1:0]   r_fail_cnt;
  logic [TW-1:0]   r_timer;

  state_t          w_state_nxt;
  logic [DW-1:0]   w_digits_nxt;
  logic [2:0]      w_cnt_nxt;
  logic [FW-1:0]   w_fail_nxt;
  logic [TW-1:0]   w_timer_nxt;
  logic            w_match;
  logic            w_last_fail;
  logic [DW-1:0]   w_disp;

  // Edge-detect history, registered events and all FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_d   <= 1'b0;
      r_num_vld_d <= 1'b0;
      r_end_d     <= 1'b0;
      r_ev_start  <= 1'b0;
      r_ev_num    <= 1'b0;
      r_ev_end    <= 1'b0;
      r_num_q     <= 4'd0;
      r_state     <= S_IDLE;
      r_digits    <= BLANK;
      r_cnt       <= 3'd0;
      r_fail_cnt  <= '0;
      r_timer     <= '0;
    end else begin
      r_start_d   <= ps_start;
      r_num_vld_d <= ps_num_valid;
      r_end_d     <= ps_end;
      r_ev_start  <= ps_start & ~r_start_d;
      r_ev_num    <= ps_num_valid & ~r_num_vld_d;
      r_ev_end    <= ps_end & ~r_end_d;
      r_num_q     <= ps_num;
      r_state     <= w_state_nxt;
      r_digits    <= w_digits_nxt;
      r_cnt       <= w_cnt_nxt;
      r_fail_cnt  <= w_fail_nxt;
      r_timer     <= w_timer_nxt;
    end
  end

  assign w_match     = (r_cnt == 3'(NUM_DIGITS)) && (r_digits == PASSCODE);
  assign w_last_fail = (({1'b0, r_fail_cnt} + 1'b1) == (FW+1)'(MAX_FAIL));

  // Next-state and datapath updates; start beats end beats digit inside ENTRY
  always_comb begin
    w_state_nxt  = r_state;
    w_digits_nxt = r_digits;
    w_cnt_nxt    = r_cnt;
    w_fail_nxt   = r_fail_cnt;
    w_timer_nxt  = r_timer;
    case (r_state)
      S_IDLE: begin
        if (r_ev_start) begin
          w_state_nxt  = S_ENTRY;
          w_digits_nxt = BLANK;
          w_cnt_nxt    = 3'd0;
        end
      end
      S_ENTRY: begin
        if (r_ev_start) begin
          w_digits_nxt = BLANK;
          w_cnt_nxt    = 3'd0;
        end else if (r_ev_end) begin
          w_state_nxt = S_CHECK;
        end else if (r_ev_num && (r_num_q <= 4'd9) && (r_cnt < 3'(NUM_DIGITS))) begin
          w_digits_nxt = {r_digits[DW-5:0], r_num_q};
          w_cnt_nxt    = r_cnt + 3'd1;
        end
      end
      S_CHECK: begin
        if (w_match) begin
          w_state_nxt = S_OPEN;
          w_fail_nxt  = '0;
          w_timer_nxt = TW'(OPEN_CYCLES - 1);
        end else if (w_last_fail) begin
          // Park the counter at its saturated value; cleared when lockout ends
          w_state_nxt = S_LOCK;
          w_fail_nxt  = FW'(MAX_FAIL - 1);
          w_timer_nxt = TW'(LOCK_CYCLES - 1);
        end else begin
          w_state_nxt = S_FAIL;
          w_fail_nxt  = r_fail_cnt + 1'b1;
        end
      end
      S_OPEN: begin
        if (r_timer == '0) begin
          w_state_nxt  = S_IDLE;
          w_digits_nxt = BLANK;
          w_cnt_nxt    = 3'd0;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      S_FAIL: begin
        w_state_nxt  = S_IDLE;
        w_digits_nxt = BLANK;
        w_cnt_nxt    = 3'd0;
      end
      S_LOCK: begin
        if (r_timer == '0) begin
          w_state_nxt  = S_IDLE;
          w_digits_nxt = BLANK;
          w_cnt_nxt    = 3'd0;
          w_fail_nxt   = '0;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_digits_nxt = BLANK;
        w_cnt_nxt    = 3'd0;
      end
    endcase
  end

  // Display view of the buffer; masking never touches the compared value
  always_comb begin
    w_disp = r_digits;
`ifdef MASK_DISPLAY_EN
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_digits[4*i +: 4] != 4'hF) w_disp[4*i +: 4] = 4'hA;
    end
`endif
  end

  assign door_open = (r_state == S_OPEN);
  assign fail      = (r_state == S_FAIL);
  assign locked    = (r_state == S_LOCK);
  assign entry_cnt = r_cnt;
  assign digits    = w_disp;
  assign state_out = r_state;

endmodule

// File: tb/tb_passcode_entry.sv
// Directed self-checking bench for passcode_entry with default parameters.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Every wait on the DUT is bounded by a cycle budget.
module tb_passcode_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps_start;
  logic [3:0]  ps_num;
  logic        ps_num_valid;
  logic        ps_end;
  logic        door_open;
  logic        fail;
  logic        locked;
  logic [2:0]  entry_cnt;
  logic [23:0] digits;
  logic [2:0]  state_out;

  int n_checks = 0;
  int n_fail   = 0;
  int open_cycles = 0;
  int lock_cycles = 0;

  passcode_entry dut (
    .clk         (clk),
    .rst         (rst),
    .ps_start    (ps_start),
    .ps_num      (ps_num),
    .ps_num_valid(ps_num_valid),
    .ps_end      (ps_end),
    .door_open   (door_open),
    .fail        (fail),
    .locked      (locked),
    .entry_cnt   (entry_cnt),
    .digits      (digits),
    .state_out   (state_out)
  );

  always #5 clk = ~clk;

  // Expected display value of a raw buffer
  function automatic logic [23:0] disp(input logic [23:0] raw);
    logic [23:0] v;
    v = raw;
`ifdef MASK_DISPLAY_EN
    for (int i = 0; i < 6; i++) if (v[4*i +: 4] != 4'hF) v[4*i +: 4] = 4'hA;
`endif
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (door_open) open_cycles++;
      if (locked)    lock_cycles++;
    end
  endtask

  task automatic press_start();
    ps_start = 1'b1; tick(); ps_start = 1'b0; tick();
  endtask

  task automatic press_digit(input logic [3:0] d);
    ps_num = d; ps_num_valid = 1'b1; tick(); ps_num_valid = 1'b0; tick();
  endtask

  task automatic press_end();
    ps_end = 1'b1; tick(); ps_end = 1'b0; tick();
  endtask

  task automatic enter_code(input logic [23:0] code);
    press_start();
    for (int i = 5; i >= 0; i--) press_digit(code[4*i +: 4]);
    press_end();
  endtask

  task automatic wait_while_open(input int budget);
    int g = 0;
    while (door_open && g < budget) begin tick(); g++; end
    if (g >= budget) check("open_timeout", 32'(door_open), 0);
  endtask

  task automatic wait_while_locked(input int budget);
    int g = 0;
    while (locked && g < budget) begin tick(); g++; end
    if (g >= budget) check("lock_timeout", 32'(locked), 0);
  endtask

  initial begin
    rst = 1'b1; ps_start = 1'b0; ps_num = 4'd0; ps_num_valid = 1'b0; ps_end = 1'b0;
    tick(2);
    // Reset state
    check("rst_state", 32'(state_out), 0);
    check("rst_door",  32'(door_open), 0);
    check("rst_fail",  32'(fail), 0);
    check("rst_lock",  32'(locked), 0);
    check("rst_cnt",   32'(entry_cnt), 0);
    check("rst_digits", 32'(digits), 32'hFFFFFF);
    rst = 1'b0;
    tick();
    check("idle_hold", 32'(state_out), 0);

    // Correct code opens for exactly 500 clocks
    press_start();
    check("entry_state", 32'(state_out), 1);
    for (int i = 1; i <= 3; i++) press_digit(4'(i));
    check("part_digits", 32'(digits), 32'(disp(24'hFFF123)));
    check("part_cnt", 32'(entry_cnt), 3);
    for (int i = 4; i <= 6; i++) press_digit(4'(i));
    check("full_digits", 32'(digits), 32'(disp(24'h123456)));
    press_end();
    check("check_state", 32'(state_out), 2);
    check("check_door", 32'(door_open), 0);
    open_cycles = 0;
    tick();
    check("open_state", 32'(state_out), 3);
    check("open_door", 32'(door_open), 1);
    wait_while_open(700);
    check("open_len", 32'(open_cycles), 500);
    check("post_open_state", 32'(state_out), 0);
    check("post_open_digits", 32'(digits), 32'hFFFFFF);
    check("post_open_cnt", 32'(entry_cnt), 0);

    // Lockout after three consecutive wrong entries
    enter_code(24'h654321);
    tick();
    check("wrong1_fail", 32'(fail), 1);
    check("wrong1_state", 32'(state_out), 4);
    tick();
    check("wrong1_pulse_end", 32'(fail), 0);
    check("wrong1_idle_digits", 32'(digits), 32'hFFFFFF);
    enter_code(24'h111111);
    tick();
    check("wrong2_fail", 32'(fail), 1);
    tick();
    enter_code(24'h000000);
    lock_cycles = 0;
    tick();
    check("wrong3_locked", 32'(locked), 1);
    check("wrong3_state", 32'(state_out), 5);
    check("wrong3_nofail", 32'(fail), 0);
    enter_code(24'h123456);
    check("lock_ignores_state", 32'(state_out), 5);
    check("lock_ignores_digits", 32'(digits), 32'(disp(24'h000000)));
    check("lock_door", 32'(door_open), 0);
    wait_while_locked(1200);
    check("lock_len", 32'(lock_cycles), 1000);
    check("post_lock_state", 32'(state_out), 0);
    check("post_lock_digits", 32'(digits), 32'hFFFFFF);
    enter_code(24'h123456);
    tick();
    check("post_lock_open", 32'(door_open), 1);
    wait_while_open(700);

    // Short entry with an invalid key
    press_start();
    press_digit(4'd1); press_digit(4'd2); press_digit(4'd3); press_digit(4'hB);
    check("short_cnt", 32'(entry_cnt), 3);
    check("short_digits", 32'(digits), 32'(disp(24'hFFF123)));
    press_end();
    tick();
    check("short_fail", 32'(fail), 1);
    check("short_door", 32'(door_open), 0);
    tick();
    check("short_idle", 32'(state_out), 0);

    // End and digit rising together: digit dropped, CHECK entered
    press_start();
    press_digit(4'd1);
    ps_end = 1'b1; ps_num = 4'd2; ps_num_valid = 1'b1;
    tick();
    ps_end = 1'b0; ps_num_valid = 1'b0;
    tick();
    check("prio_state", 32'(state_out), 2);
    check("prio_digits", 32'(digits), 32'(disp(24'hFFFFF1)));
    check("prio_cnt", 32'(entry_cnt), 1);
    tick(2);

    // Overflow: seventh digit ignored, code still matches; reset mid-OPEN
    press_start();
    for (int i = 1; i <= 7; i++) press_digit(4'(i));
    check("ovf_digits", 32'(digits), 32'(disp(24'h123456)));
    check("ovf_cnt", 32'(entry_cnt), 6);
    press_end();
    tick();
    check("ovf_open", 32'(door_open), 1);
    tick(99);
    check("mid_open", 32'(door_open), 1);
    rst = 1'b1;
    tick();
    check("rst_open_door", 32'(door_open), 0);
    check("rst_open_state", 32'(state_out), 0);
    check("rst_open_digits", 32'(digits), 32'hFFFFFF);
    check("rst_open_cnt", 32'(entry_cnt), 0);

    // Start held across reset release yields an event on the first clock
    ps_start = 1'b1;
    tick();
    rst = 1'b0;
    tick(2);
    check("held_start_entry", 32'(state_out), 1);
    tick(5);
    ps_start = 1'b0;
    tick();
    // Held digit button gives one digit
    ps_num = 4'd7; ps_num_valid = 1'b1;
    tick(20);
    ps_num_valid = 1'b0;
    tick();
    check("held_num_cnt", 32'(entry_cnt), 1);
    check("held_num_digits", 32'(digits), 32'(disp(24'hFFFFF7)));
    press_digit(4'd8);
    check("second_num", 32'(digits), 32'(disp(24'hFFFF78)));
    // Restart mid-entry
    press_start();
    check("restart_state", 32'(state_out), 1);
    check("restart_cnt", 32'(entry_cnt), 0);
    check("restart_digits", 32'(digits), 32'hFFFFFF);
    press_digit(4'd1); press_digit(4'd2);
    check("two_digits", 32'(digits), 32'(disp(24'hFFFF12)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
